// File: rtl/masked_subbytes_seq_pkg.sv
// rtl/masked_subbytes_seq_pkg.sv - shared types, constants and index helpers for the masked SubBytes sequencer
package masked_subbytes_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam logic [7:0] AES_AFFINE_C = 8'h63;

    // Bit offset of byte idx of share s in the flattened 128*SHARES state.
    function automatic int byte_lo(input int share, input logic [3:0] idx);
        return share * 128 + int'(idx) * 8;
    endfunction

    // Bit offset of share s in a flattened 8*SHARES shared byte.
    function automatic int share_lo(input int share);
        return share * 8;
    endfunction

endpackage

// File: rtl/masked_subbytes_seq_token_pipe.sv
// rtl/masked_subbytes_seq_token_pipe.sv - valid+index shift register tracking bytes in flight through the S-box
module subbytes_token_pipe #(
    parameter int DEPTH = 5
) (
    input  logic       ClkxCI,
    input  logic       RstxBI,
    input  logic       i_valid,
    input  logic [3:0] i_index,
    output logic       o_valid,
    output logic [3:0] o_index
);

    logic [DEPTH-1:0] r_valid;
    logic [3:0]       r_index [DEPTH];

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) r_index[i] <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_index[0] <= i_index;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_index[i] <= r_index[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_index = r_index[DEPTH-1];

endmodule

// File: rtl/masked_subbytes_seq.sv
// rtl/masked_subbytes_seq.sv - byte-serial masked SubBytes sequencer; SUBBYTES_AFFINE_CONST_EN adds 0x63 to share 0 on write-back
module masked_subbytes_seq
    import masked_subbytes_seq_pkg::*;
#(
    parameter int SHARES       = 2,
    parameter int SBOX_LATENCY = 5
) (
    input  logic                    ClkxCI,
    input  logic                    RstxBI,
    input  logic                    StartxSI,
    input  logic [128*SHARES-1:0]   StatexDI,
    output logic [128*SHARES-1:0]   StatexDO,
    output logic                    BusyxSO,
    output logic                    DonexSO,
    output logic [8*SHARES-1:0]     SboxInxDO,
    output logic                    SboxInValidxSO,
    input  logic [8*SHARES-1:0]     SboxOutxDI
);

    localparam int DW = $clog2(SBOX_LATENCY + 1);

    seq_state_e            r_fsm;
    logic [128*SHARES-1:0] r_state;
    logic [3:0]            r_cnt;
    logic [DW-1:0]         r_drain;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_sbox_valid;
    logic [8*SHARES-1:0]   r_sbox_in;

    logic                  w_tok_valid;
    logic [3:0]            w_tok_index;
    logic [3:0]            w_next_idx;
    logic [8*SHARES-1:0]   w_wb_data;

    assign w_next_idx = r_cnt + 4'd1;

    always_comb begin
        w_wb_data = SboxOutxDI;
`ifdef SUBBYTES_AFFINE_CONST_EN
        w_wb_data[7:0] = SboxOutxDI[7:0] ^ AES_AFFINE_C;
`endif
    end

    subbytes_token_pipe #(
        .DEPTH (SBOX_LATENCY)
    ) u_token_pipe (
        .ClkxCI  (ClkxCI),
        .RstxBI  (RstxBI),
        .i_valid (r_sbox_valid),
        .i_index (r_cnt),
        .o_valid (w_tok_valid),
        .o_index (w_tok_index)
    );

    // The S-box input is registered, so each FEED edge pre-fetches the next byte.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            r_fsm        <= ST_IDLE;
            r_state      <= '0;
            r_cnt        <= '0;
            r_drain      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_sbox_valid <= 1'b0;
            r_sbox_in    <= '0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    if (StartxSI) begin
                        r_fsm        <= ST_FEED;
                        r_cnt        <= '0;
                        r_busy       <= 1'b1;
                        r_sbox_valid <= 1'b1;
                        for (int s = 0; s < SHARES; s++)
                            r_sbox_in[share_lo(s) +: 8] <= StatexDI[byte_lo(s, 4'd0) +: 8];
                    end
                end
                ST_FEED: begin
                    r_cnt <= w_next_idx;
                    if (r_cnt == 4'd15) begin
                        r_fsm        <= ST_DRAIN;
                        r_drain      <= '0;
                        r_sbox_valid <= 1'b0;
                        r_sbox_in    <= '0;
                    end else begin
                        for (int s = 0; s < SHARES; s++)
                            r_sbox_in[share_lo(s) +: 8] <= r_state[byte_lo(s, w_next_idx) +: 8];
                    end
                end
                ST_DRAIN: begin
                    if (r_drain == DW'(SBOX_LATENCY - 1)) begin
                        r_fsm  <= ST_DONE;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_drain <= r_drain + DW'(1);
                    end
                end
                ST_DONE: begin
                    r_done <= 1'b0;
                    r_fsm  <= ST_IDLE;
                end
                default: r_fsm <= ST_IDLE;
            endcase

            if (r_fsm == ST_IDLE && StartxSI) begin
                r_state <= StatexDI;
            end else if (w_tok_valid) begin
                for (int s = 0; s < SHARES; s++)
                    r_state[byte_lo(s, w_tok_index) +: 8] <= w_wb_data[share_lo(s) +: 8];
            end
        end
    end

    assign StatexDO       = r_state;
    assign BusyxSO        = r_busy;
    assign DonexSO        = r_done;
    assign SboxInxDO      = r_sbox_in;
    assign SboxInValidxSO = r_sbox_valid;

endmodule
